// File: rtl/id_regfile_decode.sv
// Decode stage: field split, immediate generation, illegal-opcode flag and 32x32 register file.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle writeback data to the read ports.
module id_regfile_decode #(
  parameter logic [31:0] SP_INIT = 32'h0000_7FFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm32,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic        funct7_5,
  output logic [6:0]  opcode,
  output logic        illegal
);

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [4:0]  rs1, rs2;
  logic        wr_en;

  assign rd       = instruction[11:7];
  assign funct3   = instruction[14:12];
  assign funct7_5 = instruction[30];
  assign opcode   = instruction[6:0];
  assign rs1      = instruction[19:15];
  assign rs2      = instruction[24:20];
  assign wr_en    = reg_write && (wb_rd != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wb_rd] = wb_data;
  end

  // Reset has priority, so a write presented while rst is high never lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= (i == 2) ? SP_INIT : 32'd0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rs1_data = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    rs2_data = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
`ifdef ID_WB_BYPASS_EN
    if (wr_en && (wb_rd == rs1)) rs1_data = wb_data;
    if (wr_en && (wb_rd == rs2)) rs2_data = wb_data;
`else
`endif
  end

  always_comb begin
    imm32   = 32'd0;
    illegal = 1'b0;
    case (opcode)
      OP_IMM, OP_LD, OP_JALR:
        imm32 = {{20{instruction[31]}}, instruction[31:20]};
      OP_ST:
        imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      OP_BR:
        imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                 instruction[30:25], instruction[11:8], 1'b0};
      OP_LUI, OP_AUI:
        imm32 = {instruction[31:12], 12'd0};
      OP_JAL:
        imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                 instruction[20], instruction[30:21], 1'b0};
      OP_REG, OP_SYS:
        imm32 = 32'd0;
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_id_regfile_decode.sv
// Directed bench for id_regfile_decode: reset contents, write/read, x0 protection,
// immediate decode, illegal opcodes, same-cycle hazard and reset-during-write.
module tb_id_regfile_decode;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] rs1_data, rs2_data, imm32;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [6:0]  opcode;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  id_regfile_decode #(.SP_INIT(32'h0000_7FFC)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .reg_write(reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm32(imm32), .rd(rd), .funct3(funct3), .funct7_5(funct7_5),
    .opcode(opcode), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // R-type word used purely to steer the read ports.
  function automatic logic [31:0] rd_regs(input logic [4:0] a, input logic [4:0] b);
    return {7'd0, b, a, 3'd0, 5'd0, 7'b0110011};
  endfunction

  task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
    @(negedge clk);
    reg_write = 1'b1; wb_rd = r; wb_data = d;
    @(posedge clk); #1;
    reg_write = 1'b0;
  endtask

  initial begin
    rst = 1'b0; reg_write = 1'b0; wb_rd = '0; wb_data = '0; instruction = '0;
    // Reset pulse between clock edges.
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      instruction = rd_regs(5'(i), 5'(31 - i));
      #1;
      check($sformatf("reset_rs1_x%0d", i), rs1_data, (i == 2) ? 32'h0000_7FFC : 32'd0);
      check($sformatf("reset_rs2_x%0d", 31 - i), rs2_data, (31 - i == 2) ? 32'h0000_7FFC : 32'd0);
    end

    // Write x5, read on the next cycle on both ports.
    write_reg(5'd5, 32'hDEADBEEF);
    instruction = rd_regs(5'd5, 5'd5);
    #1;
    check("x5_rs1", rs1_data, 32'hDEADBEEF);
    check("x5_rs2", rs2_data, 32'hDEADBEEF);

    // x0 stays zero.
    write_reg(5'd0, 32'h0000_1234);
    instruction = rd_regs(5'd0, 5'd5);
    #1;
    check("x0_rs1", rs1_data, 32'd0);
    check("x0_rs2_x5", rs2_data, 32'hDEADBEEF);

    // Immediate decode.
    instruction = 32'hFE000EE3; #1;
    check("b_imm", imm32, 32'hFFFF_FFFC);
    check("b_illegal", {31'd0, illegal}, 32'd0);
    instruction = 32'h008000EF; #1;
    check("j_imm", imm32, 32'd8);
    check("j_rd", {27'd0, rd}, 32'd1);
    instruction = 32'h123451B7; #1;
    check("u_imm", imm32, 32'h1234_5000);
    check("u_rd", {27'd0, rd}, 32'd3);
    instruction = 32'hFE112E23; #1; // sw x1,-4(x2)
    check("s_imm", imm32, 32'hFFFF_FFFC);
    check("s_rs1_sp", rs1_data, 32'h0000_7FFC);
    check("s_funct3", {29'd0, funct3}, 32'd2);
    instruction = 32'hFFF00093; #1; // addi x1,x0,-1
    check("i_imm", imm32, 32'hFFFF_FFFF);
    check("i_opcode", {25'd0, opcode}, 32'h13);
    instruction = 32'h40B50533; #1; // sub x10,x10,x11
    check("r_imm", imm32, 32'd0);
    check("r_f7", {31'd0, funct7_5}, 32'd1);
    check("r_illegal", {31'd0, illegal}, 32'd0);
    instruction = 32'h0000_0000; #1;
    check("zero_illegal", {31'd0, illegal}, 32'd1);
    check("zero_imm", imm32, 32'd0);
    instruction = 32'hFFFF_FFFF; #1;
    check("ones_illegal", {31'd0, illegal}, 32'd1);
    check("ones_imm", imm32, 32'd0);

    // Same-cycle hazard on x7.
    write_reg(5'd7, 32'h1111_1111);
    @(negedge clk);
    instruction = rd_regs(5'd7, 5'd7);
    reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5A5_A5A5;
    #1;
`ifdef ID_WB_BYPASS_EN
    check("hazard_pre_edge", rs1_data, 32'hA5A5_A5A5);
`else
    check("hazard_pre_edge", rs1_data, 32'h1111_1111);
`endif
    @(posedge clk); #1;
    reg_write = 1'b0;
    check("hazard_post_edge", rs1_data, 32'hA5A5_A5A5);

    // Reset during a write of x9; asynchronous clear of x5 checked immediately.
    @(negedge clk);
    instruction = rd_regs(5'd9, 5'd5);
    reg_write = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
    rst = 1'b1;
    #1;
    check("async_clear_x5", rs2_data, 32'd0);
    @(posedge clk); #1;
    reg_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_write_x9", rs1_data, 32'd0);
    // First edge after release writes normally.
    write_reg(5'd9, 32'h66);
    check("post_rst_write_x9", rs1_data, 32'h66);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
